// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM burst scheduler: FSM encoding, address split,
// and the ring-buffer address step helper.
package sdram_pkg;

    localparam int BA_W   = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BA_W + ROW_W + COL_W;
    localparam int DATA_W = 16;
    localparam int FILL_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        WAIT_INIT,
        IDLE,
        WR_BUSY,
        RD_BUSY
    } sched_state_t;

    typedef enum logic {
        SRV_WR,
        SRV_RD
    } srv_t;

    // Advance a burst address by one burst, wrapping to the ring start at its end.
    function automatic logic [ADDR_W-1:0] ring_next(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W:0]   step,
        input logic [ADDR_W:0]   base,
        input logic [ADDR_W:0]   lim
    );
        logic [ADDR_W:0] nxt;
        nxt = {1'b0, addr} + step;
        if (nxt >= lim) begin
            nxt = base;
        end
        return nxt[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pushes when full and pops when empty are ignored.
module sdram_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == FULL_C);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rp_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wp_d = wp_q + AW'(1);
        end
        if (do_pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + ONE_C;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - ONE_C;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wp_q] <= din;
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// Buffers user write/read streams and schedules SDRAM burst writes/reads
// over a ring buffer in SDRAM, tracking its fill level.
module sdram_burst_sched
    import sdram_pkg::*;
#(
    parameter logic [9:0]  BURST_LEN  = 10'd8,
    parameter int          FIFO_DEPTH = 1024,
    parameter logic [23:0] BASE_ADDR  = 24'd0,
    parameter logic [23:0] END_ADDR   = 24'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        usr_wr_en,
    input  logic [15:0] usr_wr_data,
    output logic        usr_wr_full,
    input  logic        usr_rd_en,
    output logic [15:0] usr_rd_data,
    output logic        usr_rd_empty,
    output logic        ovf_err,
    output logic        wr_req,
    input  logic        wr_ack,
    input  logic        wr_end,
    output logic [23:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    input  logic        rd_end,
    output logic [23:0] rd_addr,
    output logic [9:0]  burst_len
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] BL32    = 32'(BURST_LEN);
    localparam logic [31:0] CAP32   = 32'(END_ADDR) - 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH32 = 32'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] STEP_C = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0] BASE_C = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] LIM_C  = (ADDR_W+1)'(END_ADDR);

    sched_state_t      state_q, state_d;
    srv_t              last_q, last_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       urd_q, urd_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic [CW-1:0] wcnt, rcnt;
    logic [15:0]   rdout;
    logic          wfull, wempty;
    logic          rfull, rempty;
    logic          wpop, rpush, rpop;
    logic          can_wr, can_rd;

    // Acks only move data while the matching burst is in flight.
    assign wpop  = wr_ack && (state_q == WR_BUSY) && !wempty;
    assign rpush = rd_ack && (state_q == RD_BUSY) && !rfull;
    assign rpop  = usr_rd_en && !rempty;

    sdram_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_wfifo (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .push     (usr_wr_en),
        .din      (usr_wr_data),
        .pop      (wpop),
        .dout     (wr_data),
        .count    (wcnt),
        .full     (wfull),
        .empty    (wempty)
    );

    sdram_sync_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_rfifo (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .push     (rpush),
        .din      (rd_data),
        .pop      (rpop),
        .dout     (rdout),
        .count    (rcnt),
        .full     (rfull),
        .empty    (rempty)
    );

    assign can_wr = (32'(wcnt) >= BL32) && (32'(fill_q) + BL32 <= CAP32);
    assign can_rd = (32'(fill_q) >= BL32) && (DEPTH32 - 32'(rcnt) >= BL32);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        wa_d     = wa_q;
        ra_d     = ra_q;
        fill_d   = fill_q;
        unique case (state_q)
            WAIT_INIT: begin
                if (init_end) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (can_wr && (!can_rd || last_q == SRV_RD)) begin
                    wr_req_d = 1'b1;
                    state_d  = WR_BUSY;
                end else if (can_rd) begin
                    rd_req_d = 1'b1;
                    state_d  = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (wr_end) begin
                    wr_req_d = 1'b0;
                    fill_d   = fill_q + FILL_W'(BURST_LEN);
                    wa_d     = ring_next(wa_q, STEP_C, BASE_C, LIM_C);
                    last_d   = SRV_WR;
                    state_d  = IDLE;
                end
            end
            RD_BUSY: begin
                if (rd_end) begin
                    rd_req_d = 1'b0;
                    fill_d   = fill_q - FILL_W'(BURST_LEN);
                    ra_d     = ring_next(ra_q, STEP_C, BASE_C, LIM_C);
                    last_d   = SRV_RD;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = WAIT_INIT;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q || (usr_wr_en && wfull);
        urd_d = rpop ? rdout : urd_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= WAIT_INIT;
            last_q   <= SRV_RD;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            ovf_q    <= 1'b0;
            urd_q    <= '0;
            wa_q     <= BASE_ADDR;
            ra_q     <= BASE_ADDR;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            ovf_q    <= ovf_d;
            urd_q    <= urd_d;
            wa_q     <= wa_d;
            ra_q     <= ra_d;
            fill_q   <= fill_d;
        end
    end

    assign wr_req       = wr_req_q;
    assign rd_req       = rd_req_q;
    assign wr_addr      = wa_q;
    assign rd_addr      = ra_q;
    assign ovf_err      = ovf_q;
    assign usr_rd_data  = urd_q;
    assign usr_wr_full  = wfull;
    assign usr_rd_empty = rempty;
    assign burst_len    = BURST_LEN;

endmodule
